// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between uart_core, the receive FIFO and the mod_uart bus decode.
// The FIFO side uses the slave modport. The core/bus side uses the master modport.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    // Handshake rules:
    // - Core to FIFO:
    //   - rx_rdy is a level that behaves as "valid". It stays high until the FIFO answers with one rx_clear pulse.
    //   - The byte counts as taken on the edge where rx_clear is sampled high.
    //   - The byte also counts as taken when it is dropped on overflow.
    // - Bus to FIFO:
    //   - pop is a one-cycle request that consumes the entry currently shown on dout.
    //   - When the FIFO is empty, pop is ignored.
    logic [7:0]          rx_byte;
    logic                rx_rdy;
    logic                rx_clear;
    logic                pop;
    logic [7:0]          dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                ovf_clear;
    logic [1:0]          fsm_state;

    modport slave (
        input  rx_byte, rx_rdy, pop, ovf_clear,
        output rx_clear, dout, empty, full, count, overflow, fsm_state
    );

    modport master (
        output rx_byte, rx_rdy, pop, ovf_clear,
        input  rx_clear, dout, empty, full, count, overflow, fsm_state
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_core. It captures each data_rdy byte exactly once and acknowledges it through clear.
// The bus pops bytes in arrival order. All state changes on the falling clock edge.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               rx_clear_q, rx_clear_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [DEPTH];

    logic empty;
    logic full;
    logic push_req;
    logic do_push;
    logic do_pop;
    logic ovf_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Capture FSM: one push per data_rdy assertion, regardless of how long the core holds it.
    always_comb begin
        state_d    = state_q;
        rx_clear_d = 1'b0;
        push_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_rdy) begin
                    push_req   = 1'b1;
                    rx_clear_d = 1'b1;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.rx_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A same-edge pop frees a slot, so a push into a full FIFO still succeeds in that case.
    always_comb begin
        do_pop     = bus.pop && !empty;
        do_push    = push_req && (!full || do_pop);
        ovf_set    = push_req && full && !do_pop;
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        overflow_d = overflow_q;
        if (bus.ovf_clear) begin
            overflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_clear_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_clear_q <= rx_clear_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; stale entries are never visible because count gates dout.
    always_ff @(negedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= bus.rx_byte;
        end
    end

    assign bus.rx_clear  = rx_clear_q;
    assign bus.dout      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. A small uart_core model feeds bytes, and a queue of expected bytes tracks FIFO contents.
// Inputs are driven and outputs are sampled on the rising edge, away from the falling update edge.
module tb_uart_rx_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic rst;

    uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    endfunction

    // Models uart_core: hold data_rdy until clear is seen, then drop it on that edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        @(posedge clk);
        check_eq("rx_clear_high", 32'(bus.rx_clear), 32'd1);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        check_eq("count_after_push", 32'(bus.count), 32'(exp_q.size()));
        check_eq("overflow_after_push", 32'(bus.overflow), 32'(exp_ovf));
        bus.rx_rdy = 1'b0;
        @(posedge clk);
        check_eq("rx_clear_pulse_end", 32'(bus.rx_clear), 32'd0);
        @(posedge clk);
    endtask

    task automatic pop_check(input string tag);
        @(posedge clk);
        check_eq(tag, 32'(bus.dout), 32'(exp_head()));
        bus.pop = 1'b1;
        @(posedge clk);
        bus.pop = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_eq({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    endtask

    // Push and pop on the same falling edge.
    task automatic push_pop(input logic [7:0] b);
        @(posedge clk);
        check_eq("pp_dout", 32'(bus.dout), 32'(exp_head()));
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        bus.pop     = 1'b1;
        @(posedge clk);
        bus.pop = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(b);
        check_eq("pp_rx_clear", 32'(bus.rx_clear), 32'd1);
        check_eq("pp_count", 32'(bus.count), 32'(exp_q.size()));
        check_eq("pp_overflow", 32'(bus.overflow), 32'(exp_ovf));
        bus.rx_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic clear_ovf();
        @(posedge clk);
        bus.ovf_clear = 1'b1;
        @(posedge clk);
        bus.ovf_clear = 1'b0;
        exp_ovf = 1'b0;
        check_eq("ovf_cleared", 32'(bus.overflow), 32'd0);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        @(posedge clk);
        check_eq({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check_eq({tag, "_dout0"}, 32'(bus.dout), 32'd0);
    endtask

    initial begin
        int pulses;
        n_checks      = 0;
        n_fail        = 0;
        exp_ovf       = 1'b0;
        rst           = 1'b1;
        bus.rx_byte   = 8'h00;
        bus.rx_rdy    = 1'b0;
        bus.pop       = 1'b0;
        bus.ovf_clear = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);

        // reset state
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_rx_clear", 32'(bus.rx_clear), 32'd0);
        check_eq("rst_fsm", 32'(bus.fsm_state), 32'd0);

        // single byte
        send_byte(8'h41);
        check_eq("t1_dout", 32'(bus.dout), 32'h41);
        check_eq("t1_empty", 32'(bus.empty), 32'd0);
        drain("t1_pop");

        // fill and drain in order
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i));
        check_eq("t2_full", 32'(bus.full), 32'd1);
        drain("t2_pop");
        check_eq("t2_full_after", 32'(bus.full), 32'd0);

        // overflow
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h11 + i));
        send_byte(8'hAA);
        check_eq("t3_ovf", 32'(bus.overflow), 32'd1);
        check_eq("t3_count", 32'(bus.count), 32'(DEPTH));
        pop_check("t3_pop");
        clear_ovf();

        // full with simultaneous push and pop
        send_byte(8'h33);
        check_eq("t4_full", 32'(bus.full), 32'd1);
        push_pop(8'h55);
        drain("t4_pop");

        // pop on empty, then push+pop on empty
        pop_check("t5_pop_empty");
        check_eq("t5_empty", 32'(bus.empty), 32'd1);
        push_pop(8'h7E);
        check_eq("t5_dout", 32'(bus.dout), 32'h7E);
        drain("t5_pop");

        // stuck rx_rdy, then reset while in WAIT
        send_byte(8'h21);
        send_byte(8'h22);
        @(posedge clk);
        bus.rx_byte = 8'h99;
        bus.rx_rdy  = 1'b1;
        pulses      = 0;
        repeat (10) begin
            @(posedge clk);
            if (bus.rx_clear) pulses++;
        end
        exp_q.push_back(8'h99);
        check_eq("t6_one_pulse", 32'(pulses), 32'd1);
        check_eq("t6_count", 32'(bus.count), 32'(exp_q.size()));
        check_eq("t6_fsm_wait", 32'(bus.fsm_state), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        check_eq("t6_rst_count", 32'(bus.count), 32'd0);
        check_eq("t6_rst_rx_clear", 32'(bus.rx_clear), 32'd0);
        check_eq("t6_rst_fsm", 32'(bus.fsm_state), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        exp_q.push_back(8'h99);
        check_eq("t6_fresh_clear", 32'(bus.rx_clear), 32'd1);
        check_eq("t6_fresh_count", 32'(bus.count), 32'd1);
        check_eq("t6_fresh_dout", 32'(bus.dout), 32'h99);
        bus.rx_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        drain("t6_pop");

        // random mix
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) send_byte(8'($urandom_range(0, 255)));
            else pop_check("rand_pop");
        end
        check_eq("rand_ovf", 32'(bus.overflow), 32'(exp_ovf));
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
